fetch_queue: RTL

- Instruction fetch front end. It owns the program counter and issues sequential reads to instruction memory.
- Returned words are buffered in a small prefetch FIFO. The decoder consumes them through a valid/ready handshake.
- Branch/jump logic redirects the PC through `redirect`, which flushes all prefetched and in-flight words.
- This is the consumer side of the PC/instruction-memory path.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues sequential reads, buffers returns in a prefetch FIFO.
// Optional stall counter output (stall_cnt) is enabled with `define FETCH_PERF_EN.
module fetch_queue #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = PW + 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_req_pc;
    logic          r_inflight;
    logic          r_kill;

    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [OW-1:0] w_occupancy;
    entry_t        w_head;

    // Credit check counts the in-flight word; a same-cycle pop earns no credit.
    assign w_occupancy = OW'(r_count) + OW'(r_inflight);
    assign w_req       = !reset && !redirect && (w_occupancy < OW'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_push      = r_inflight && !redirect && !r_kill;
    assign w_pop       = w_valid && instr_ready && !redirect;
    assign w_head      = r_mem[r_rptr];

    assign mem_req     = w_req;
    assign mem_addr    = r_pc;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? w_head.word : '0;
    assign instr_pc    = w_valid ? w_head.pc   : '0;

    // Control state: PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_kill <= redirect;
            if (redirect) begin
                r_pc       <= redirect_addr;
                r_inflight <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_req;
                if (w_req) begin
                    r_pc     <= r_pc + AW'(1);
                    r_req_pc <= r_pc;
                end
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Prefetch storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{pc: r_req_pc, word: mem_rdata};
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall;

    // Cycles where the decoder was ready but had nothing to take, excluding redirect cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (instr_ready && !w_valid && !redirect && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
